int_gen: RTL and testbench

//  Interrupt-source responder on the CPU's external-interrupt window (Int bridge slot).

---
 rtl/int_gen.sv | 129 ++++++++++++
 tb/tb_int_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/int_gen.sv
// Interrupt-source responder for the CPU's external-interrupt window.
// Raises a request after a programmable delay and holds it until a window store acknowledges it.
module int_gen #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_7F20,
    parameter logic [31:0] END_ADDR      = 32'h0000_7F23,
    parameter logic [31:0] DEFAULT_DELAY = 32'd100,
    parameter logic [31:0] TIMEOUT       = 32'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    input  logic        cfg_we,
    input  logic [31:0] cfg_delay,
    input  logic [15:0] cfg_count,
    output logic        interrupt,
    output logic        busy,
    output logic [15:0] ack_cnt,
    output logic        timeout_err,
    output logic        spurious
);

    // state  | meaning
    // IDLE   | nothing programmed, waiting for cfg_we
    // COUNT  | counting delay edges toward the next request
    // ASSERT | interrupt high, waiting for a window store
    // DONE   | all programmed requests acknowledged
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ASSERT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_delay;
    logic [15:0] r_remaining;
    logic        r_interrupt;
    logic [15:0] r_ack_cnt;
    logic        r_timeout_err;
    logic        r_spurious;

    state_t      w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_delay_nxt;
    logic [15:0] w_remaining_nxt;
    logic [15:0] w_ack_cnt_nxt;
    logic        w_timeout_err_nxt;
    logic        w_spurious_nxt;
    logic        w_hit;

    assign w_hit = (m_int_addr >= BASE_ADDR) && (m_int_addr <= END_ADDR) && (|m_int_byteen);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= 32'd0;
            r_delay       <= DEFAULT_DELAY;
            r_remaining   <= 16'd0;
            r_interrupt   <= 1'b0;
            r_ack_cnt     <= 16'd0;
            r_timeout_err <= 1'b0;
            r_spurious    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_delay       <= w_delay_nxt;
            r_remaining   <= w_remaining_nxt;
            r_interrupt   <= (w_state_nxt == ASSERT);
            r_ack_cnt     <= w_ack_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_spurious    <= w_spurious_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_delay_nxt       = r_delay;
        w_remaining_nxt   = r_remaining;
        w_ack_cnt_nxt     = r_ack_cnt;
        w_timeout_err_nxt = r_timeout_err;
        w_spurious_nxt    = r_spurious;

        if (cfg_we) begin
            // Reconfiguration overrides everything, including a same-cycle ack.
            w_delay_nxt     = (cfg_delay == 32'd0) ? 32'd1 : cfg_delay;
            w_remaining_nxt = cfg_count;
            w_cnt_nxt       = 32'd0;
            w_state_nxt     = (cfg_count != 16'd0) ? COUNT : IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_hit) w_spurious_nxt = 1'b1;
                end
                COUNT: begin
                    if (w_hit) w_spurious_nxt = 1'b1;
                    if (r_cnt == r_delay - 32'd1) begin
                        w_state_nxt = ASSERT;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                ASSERT: begin
                    if (w_hit) begin
                        if (r_ack_cnt != 16'hFFFF) w_ack_cnt_nxt = r_ack_cnt + 16'd1;
                        w_remaining_nxt = r_remaining - 16'd1;
                        w_cnt_nxt       = 32'd0;
                        w_state_nxt     = (r_remaining == 16'd1) ? DONE : COUNT;
                    end else begin
                        // cnt saturates so a long-unserviced request cannot wrap.
                        if (r_cnt < TIMEOUT) w_cnt_nxt = r_cnt + 32'd1;
                        if (w_cnt_nxt >= TIMEOUT) w_timeout_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign interrupt   = r_interrupt;
    assign busy        = (r_state == COUNT) || (r_state == ASSERT);
    assign ack_cnt     = r_ack_cnt;
    assign timeout_err = r_timeout_err;
    assign spurious    = r_spurious;

endmodule

// File: tb/tb_int_gen.sv
// Directed bench for int_gen: delay timing, acks, window decode, timeout, spurious and reset.
module tb_int_gen;

    logic        clk;
    logic        reset;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        cfg_we;
    logic [31:0] cfg_delay;
    logic [15:0] cfg_count;
    logic        interrupt;
    logic        busy;
    logic [15:0] ack_cnt;
    logic        timeout_err;
    logic        spurious;

    int n_checks = 0;
    int n_fail   = 0;

    int_gen #(
        .BASE_ADDR    (32'h0000_7F20),
        .END_ADDR     (32'h0000_7F23),
        .DEFAULT_DELAY(32'd100),
        .TIMEOUT      (32'd8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_int_addr  (m_int_addr),
        .m_int_byteen(m_int_byteen),
        .cfg_we      (cfg_we),
        .cfg_delay   (cfg_delay),
        .cfg_count   (cfg_count),
        .interrupt   (interrupt),
        .busy        (busy),
        .ack_cnt     (ack_cnt),
        .timeout_err (timeout_err),
        .spurious    (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] d, input logic [15:0] c);
        cfg_we    = 1'b1;
        cfg_delay = d;
        cfg_count = c;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be);
        m_int_addr   = a;
        m_int_byteen = be;
        tick(1);
        m_int_addr   = 32'd0;
        m_int_byteen = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        reset        = 1'b0;
        m_int_addr   = 32'd0;
        m_int_byteen = 4'd0;
        cfg_we       = 1'b0;
        cfg_delay    = 32'd0;
        cfg_count    = 16'd0;

        // 1. reset held across edges
        tick(3);
        chk_eq("rst_interrupt", interrupt, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_ack_cnt", ack_cnt, 0);
        chk_eq("rst_timeout", timeout_err, 0);
        chk_eq("rst_spurious", spurious, 0);
        reset = 1'b1;
        tick(2);
        chk_eq("idle_interrupt", interrupt, 0);

        // 2. delay=5 count=1
        cfg(5, 1);
        chk_eq("t2_busy", busy, 1);
        tick(4);
        chk_eq("t2_low_at_4", interrupt, 0);
        tick(1);
        chk_eq("t2_high_at_5", interrupt, 1);
        store(32'h7F20, 4'b1111);
        chk_eq("t2_ack_int", interrupt, 0);
        chk_eq("t2_ack_cnt", ack_cnt, 1);
        chk_eq("t2_busy_done", busy, 0);

        // 3. delay=2 count=3, three acked pulses
        cfg(2, 3);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_eq("t3_low", interrupt, 0);
            tick(1);
            chk_eq("t3_high", interrupt, 1);
            store(32'h7F22, 4'b0001);
            chk_eq("t3_ack_int", interrupt, 0);
            chk_eq("t3_ack_cnt", ack_cnt, 32'(2 + k));
            chk_eq("t3_busy", busy, (k < 2) ? 1 : 0);
        end

        // 4. window decode and spurious stores
        cfg(3, 1);
        tick(3);
        chk_eq("t4_high", interrupt, 1);
        store(32'h7F24, 4'b1111);
        chk_eq("t4_out_of_window_int", interrupt, 1);
        chk_eq("t4_out_of_window_ack", ack_cnt, 4);
        store(32'h7F20, 4'b0000);
        chk_eq("t4_no_byteen_int", interrupt, 1);
        chk_eq("t4_no_byteen_ack", ack_cnt, 4);
        chk_eq("t4_no_spurious_yet", spurious, 0);
        store(32'h7F23, 4'b1000);
        chk_eq("t4_ack_end_addr", ack_cnt, 5);
        chk_eq("t4_ack_int", interrupt, 0);
        cfg(4, 1);
        tick(1);
        store(32'h7F21, 4'b1111);
        chk_eq("t4_spurious", spurious, 1);
        chk_eq("t4_spurious_ack_cnt", ack_cnt, 5);
        chk_eq("t4_spurious_busy", busy, 1);
        waited = 0;
        while (interrupt !== 1'b1 && waited < 10) begin
            tick(1);
            waited++;
        end
        chk_eq("t4_request_after_spurious", interrupt, 1);
        store(32'h7F20, 4'b1111);
        chk_eq("t4_ack2_cnt", ack_cnt, 6);

        // 5. timeout with TIMEOUT=8
        cfg(1, 1);
        tick(1);
        chk_eq("t5_high", interrupt, 1);
        tick(7);
        chk_eq("t5_no_timeout_7", timeout_err, 0);
        tick(1);
        chk_eq("t5_timeout_8", timeout_err, 1);
        chk_eq("t5_int_held", interrupt, 1);
        tick(3);
        chk_eq("t5_int_still_held", interrupt, 1);
        store(32'h7F20, 4'b1111);
        chk_eq("t5_late_ack_int", interrupt, 0);
        chk_eq("t5_late_ack_cnt", ack_cnt, 7);
        chk_eq("t5_timeout_sticky", timeout_err, 1);

        // 6. cfg_we beats a same-cycle ack; async reset mid-ASSERT
        cfg(2, 2);
        tick(2);
        chk_eq("t6_high", interrupt, 1);
        cfg_we       = 1'b1;
        cfg_delay    = 32'd3;
        cfg_count    = 16'd1;
        m_int_addr   = 32'h7F20;
        m_int_byteen = 4'b1111;
        tick(1);
        cfg_we       = 1'b0;
        m_int_addr   = 32'd0;
        m_int_byteen = 4'd0;
        chk_eq("t6_reconfig_int", interrupt, 0);
        chk_eq("t6_reconfig_ack_cnt", ack_cnt, 7);
        chk_eq("t6_reconfig_busy", busy, 1);
        tick(2);
        chk_eq("t6_low_at_2", interrupt, 0);
        tick(1);
        chk_eq("t6_high_at_3", interrupt, 1);
        reset = 1'b0;
        #1;
        chk_eq("t6_async_rst_int", interrupt, 0);
        chk_eq("t6_async_rst_busy", busy, 0);
        chk_eq("t6_async_rst_ack", ack_cnt, 0);
        chk_eq("t6_async_rst_timeout", timeout_err, 0);
        chk_eq("t6_async_rst_spurious", spurious, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk_eq("t6_after_rst_int", interrupt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
